core_decode: RTL and testbench

RV32I instruction decode stage, directly downstream of instruction fetch. Consumes the fetched instruction word, its PC and valid flag, extracts register addresses, the sign-extended immediate and the execute/memory control fields, and presents them from a single pipeline register to the execute stage. Honors the shared pipeline stall and flush controls and flags illegal encodings.

---
 rtl/core_pkg.sv | 99 +++++++++
 rtl/core_decode_if.sv | 49 ++++
 rtl/core_imm_gen.sv | 29 ++
 rtl/core_decode.sv | 162 ++++++++++++++++
 tb/tb_core_decode.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types for the RV32I decode stage.
// Holds the ALU operation enum (M-extension ops always listed), the opcode
// map, memory access sizes and the registered decode bundle.
package core_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        mem_req;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [2:0]  branch_cond;
        logic        ecall;
        logic        ebreak;
        logic        fence;
        logic        illegal;
    } decode_t;

    // Bubble / reset contents: nothing valid, no side effects.
    localparam decode_t DECODE_NONE = '0;

    // Base integer op for a funct3; alt selects SUB/SRA variants.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // M-extension op selected by funct3.
    function automatic alu_op_e m_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return ALU_MUL;
            3'd1:    return ALU_MULH;
            3'd2:    return ALU_MULHSU;
            3'd3:    return ALU_MULHU;
            3'd4:    return ALU_DIV;
            3'd5:    return ALU_DIVU;
            3'd6:    return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/core_decode_if.sv
// core_decode_if: fetch-to-decode inputs and decode-to-execute bundle.
// Handshake: the decoder captures instruction_i/pc_i on a clock edge when
// instruction_valid_i is high and stall_i is low; flush_i overrides stall_i.
// valid_o qualifies every output field; side-effect controls are 0 when low.
interface core_decode_if;
    logic [31:0] instruction_i;
    logic        instruction_valid_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic [31:0] imm_o;
    logic [4:0]  alu_op_o;
    logic        alu_src_a_o;
    logic        alu_src_b_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [1:0]  mem_size_o;
    logic        mem_unsigned_o;
    logic        branch_o;
    logic        jal_o;
    logic        jalr_o;
    logic [2:0]  branch_cond_o;
    logic        ecall_o;
    logic        ebreak_o;
    logic        fence_o;
    logic        illegal_o;

    modport master (
        output instruction_i, instruction_valid_i, pc_i, stall_i, flush_i,
        input  valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o,
               alu_op_o, alu_src_a_o, alu_src_b_o, mem_req_o, mem_we_o, mem_size_o,
               mem_unsigned_o, branch_o, jal_o, jalr_o, branch_cond_o, ecall_o,
               ebreak_o, fence_o, illegal_o
    );

    modport slave (
        input  instruction_i, instruction_valid_i, pc_i, stall_i, flush_i,
        output valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o,
               alu_op_o, alu_src_a_o, alu_src_b_o, mem_req_o, mem_we_o, mem_size_o,
               mem_unsigned_o, branch_o, jal_o, jalr_o, branch_cond_o, ecall_o,
               ebreak_o, fence_o, illegal_o
    );
endinterface

// File: rtl/core_imm_gen.sv
// core_imm_gen: combinational immediate extraction by instruction format.
// Opcodes without an immediate produce 0.
import core_pkg::*;

module core_imm_gen (
    input  logic [31:0] instruction_i,
    output logic [31:0] imm_o
);
    // Select I/S/B/U/J layout from the opcode and sign-extend bit 31.
    always_comb begin
        imm_o = '0;
        case (instruction_i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM:
                imm_o = {{20{instruction_i[31]}}, instruction_i[31:20]};
            OPC_STORE:
                imm_o = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {instruction_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end
endmodule

// File: rtl/core_decode.sv
// core_decode: RV32I decode stage with a single output pipeline register.
// Optional feature: define AURIGA_RV32M_EN to decode the M extension
// (OP with funct7 = 0000001); otherwise those encodings are illegal.
import core_pkg::*;

module core_decode (
    input  logic          clk_i,
    input  logic          rst_n_i,
    core_decode_if.slave  dec
);
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    decode_t     d_next;
    decode_t     d_q;

    assign instr  = dec.instruction_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    core_imm_gen u_imm_gen (
        .instruction_i (instr),
        .imm_o         (imm)
    );

    // Decode the incoming word into the next bundle; illegal and bubble
    // cases strip all side-effect controls.
    always_comb begin
        d_next          = DECODE_NONE;
        illegal         = 1'b0;
        d_next.valid    = 1'b1;
        d_next.pc       = dec.pc_i;
        d_next.rs1_addr = instr[19:15];
        d_next.rs2_addr = instr[24:20];
        d_next.rd_addr  = instr[11:7];
        d_next.imm      = imm;
        case (opcode)
            OPC_LUI: begin
                d_next.rs1_addr  = '0;
                d_next.alu_src_b = 1'b1;
                d_next.rd_we     = 1'b1;
            end
            OPC_AUIPC: begin
                d_next.alu_src_a = 1'b1;
                d_next.alu_src_b = 1'b1;
                d_next.rd_we     = 1'b1;
            end
            OPC_JAL: begin
                d_next.jal       = 1'b1;
                d_next.rd_we     = 1'b1;
                d_next.alu_src_a = 1'b1;
                d_next.alu_src_b = 1'b1;
            end
            OPC_JALR: begin
                d_next.jalr      = 1'b1;
                d_next.rd_we     = 1'b1;
                d_next.alu_src_b = 1'b1;
                illegal          = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                d_next.branch      = 1'b1;
                d_next.branch_cond = funct3;
                d_next.alu_op      = ALU_SUB;
                illegal            = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                d_next.mem_req      = 1'b1;
                d_next.mem_size     = funct3[1:0];
                d_next.mem_unsigned = funct3[2];
                d_next.rd_we        = 1'b1;
                d_next.alu_src_b    = 1'b1;
                illegal             = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
            end
            OPC_STORE: begin
                d_next.mem_req   = 1'b1;
                d_next.mem_we    = 1'b1;
                d_next.mem_size  = funct3[1:0];
                d_next.alu_src_b = 1'b1;
                illegal          = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                d_next.rd_we     = 1'b1;
                d_next.alu_src_b = 1'b1;
                d_next.alu_op    = base_alu_op(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1) illegal = (funct7 != 7'h00);
                if (funct3 == 3'd5) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP: begin
                d_next.rd_we = 1'b1;
                if (funct7 == 7'h00) begin
                    d_next.alu_op = base_alu_op(funct3, 1'b0);
                end else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    d_next.alu_op = base_alu_op(funct3, 1'b1);
`ifdef AURIGA_RV32M_EN
                end else if (funct7 == 7'h01) begin
                    d_next.alu_op = m_alu_op(funct3);
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                d_next.fence = 1'b1;
                illegal      = (funct3 != 3'd0);
            end
            OPC_SYSTEM: begin
                if (instr == 32'h0000_0073)      d_next.ecall  = 1'b1;
                else if (instr == 32'h0010_0073) d_next.ebreak = 1'b1;
                else                             illegal       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (d_next.rd_addr == 5'd0) d_next.rd_we = 1'b0;
        if (illegal) begin
            d_next.rd_we   = 1'b0;
            d_next.mem_req = 1'b0;
            d_next.mem_we  = 1'b0;
            d_next.branch  = 1'b0;
            d_next.jal     = 1'b0;
            d_next.jalr    = 1'b0;
            d_next.ecall   = 1'b0;
            d_next.ebreak  = 1'b0;
            d_next.fence   = 1'b0;
        end
        d_next.illegal = illegal;
        if (!dec.instruction_valid_i) d_next = DECODE_NONE;
    end

    // Pipeline register: reset > flush > stall > load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          d_q <= DECODE_NONE;
        else if (dec.flush_i)  d_q <= DECODE_NONE;
        else if (!dec.stall_i) d_q <= d_next;
    end

    assign dec.valid_o        = d_q.valid;
    assign dec.pc_o           = d_q.pc;
    assign dec.rs1_addr_o     = d_q.rs1_addr;
    assign dec.rs2_addr_o     = d_q.rs2_addr;
    assign dec.rd_addr_o      = d_q.rd_addr;
    assign dec.rd_we_o        = d_q.rd_we;
    assign dec.imm_o          = d_q.imm;
    assign dec.alu_op_o       = d_q.alu_op;
    assign dec.alu_src_a_o    = d_q.alu_src_a;
    assign dec.alu_src_b_o    = d_q.alu_src_b;
    assign dec.mem_req_o      = d_q.mem_req;
    assign dec.mem_we_o       = d_q.mem_we;
    assign dec.mem_size_o     = d_q.mem_size;
    assign dec.mem_unsigned_o = d_q.mem_unsigned;
    assign dec.branch_o       = d_q.branch;
    assign dec.jal_o          = d_q.jal;
    assign dec.jalr_o         = d_q.jalr;
    assign dec.branch_cond_o  = d_q.branch_cond;
    assign dec.ecall_o        = d_q.ecall;
    assign dec.ebreak_o       = d_q.ebreak;
    assign dec.fence_o        = d_q.fence;
    assign dec.illegal_o      = d_q.illegal;
endmodule

// File: tb/tb_core_decode.sv
// tb_core_decode: table vectors, hand sequences for stall/flush/reset,
// and randomized traffic against an instruction-level reference model.
import core_pkg::*;

module tb_core_decode;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [4:0]  alu_op;
        logic        src_a, src_b;
        logic        mem_req, mem_we;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch, jal, jalr;
        logic [2:0]  branch_cond;
        logic        ecall, ebreak, fence, illegal;
    } out_t;

    typedef struct {
        logic [31:0] ins;
        logic        illegal, rd_we, mem_req, mem_we;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        src_b;
        logic [1:0]  size;
        logic        c_rs1, c_rs2, c_imm, c_alu;
    } vec_t;

`ifdef AURIGA_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam alu_op_e BASE_OPS[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                        ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam alu_op_e M_OPS[8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                     ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    localparam logic [6:0] OPS[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                       7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    core_decode_if bus ();

    core_decode dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .dec     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic out_t ctl_mask();
        out_t m = '0;
        m.valid = 1'b1; m.rd_we = 1'b1; m.mem_req = 1'b1; m.mem_we = 1'b1;
        m.branch = 1'b1; m.jal = 1'b1; m.jalr = 1'b1; m.ecall = 1'b1;
        m.ebreak = 1'b1; m.fence = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       output out_t e, output out_t m);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        int ii = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        int si = int'({ins[30:25], ins[11:7]}) - (ins[31] ? 2048 : 0);
        int bi = int'({ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 4096 : 0);
        int ji = int'({ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 1048576 : 0);
        logic legal = 1'b1;
        e = '0; m = '0;
        e.valid = 1'b1; e.pc = pc;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        case (op)
            7'h37: begin
                e.rd_we = 1; e.rs1 = 0; e.imm = {ins[31:12], 12'h000}; e.alu_op = ALU_ADD; e.src_b = 1;
                m.rd = '1; m.rs1 = '1; m.imm = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1;
            end
            7'h17: begin
                e.rd_we = 1; e.imm = {ins[31:12], 12'h000}; e.alu_op = ALU_ADD; e.src_a = 1; e.src_b = 1;
                m.rd = '1; m.imm = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1;
            end
            7'h6F: begin
                e.jal = 1; e.rd_we = 1; e.imm = 32'(ji);
                m.rd = '1; m.imm = '1;
            end
            7'h67: begin
                legal = (f3 == 0); e.jalr = 1; e.rd_we = 1; e.imm = 32'(ii);
                m.rd = '1; m.rs1 = '1; m.imm = '1;
            end
            7'h63: begin
                legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
                e.branch = 1; e.branch_cond = f3; e.imm = 32'(bi);
                m.rs1 = '1; m.rs2 = '1; m.imm = '1; m.branch_cond = '1;
            end
            7'h03: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.mem_req = 1; e.rd_we = 1; e.mem_size = 2'(f3 % 4); e.mem_unsigned = (f3 >= 4);
                e.imm = 32'(ii); e.alu_op = ALU_ADD; e.src_b = 1;
                m.rd = '1; m.rs1 = '1; m.imm = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1;
                m.mem_size = '1; m.mem_unsigned = 1;
            end
            7'h23: begin
                legal = (f3 <= 2); e.mem_req = 1; e.mem_we = 1; e.mem_size = f3[1:0];
                e.imm = 32'(si); e.alu_op = ALU_ADD; e.src_b = 1;
                m.rs1 = '1; m.rs2 = '1; m.imm = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1; m.mem_size = '1;
            end
            7'h13: begin
                e.rd_we = 1; e.imm = 32'(ii); e.src_b = 1; e.alu_op = BASE_OPS[f3];
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) e.alu_op = ALU_SRA;
                end
                m.rd = '1; m.rs1 = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1;
                if (f3 != 1 && f3 != 5) m.imm = '1;
            end
            7'h33: begin
                e.rd_we = 1;
                if (f7 == 7'h00) e.alu_op = BASE_OPS[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.alu_op = ALU_SRA;
                else if (f7 == 7'h01 && M_EN) e.alu_op = M_OPS[f3];
                else legal = 1'b0;
                m.rd = '1; m.rs1 = '1; m.rs2 = '1; m.alu_op = '1; m.src_a = 1; m.src_b = 1;
            end
            7'h0F: begin
                legal = (f3 == 0); e.fence = 1;
            end
            7'h73: begin
                if (ins == 32'h0000_0073)      e.ecall = 1;
                else if (ins == 32'h0010_0073) e.ebreak = 1;
                else                           legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (e.rd == 0) e.rd_we = 0;
        if (!legal) begin
            e = '0; e.valid = 1; e.pc = pc; e.illegal = 1; m = '0;
        end
        m = m | ctl_mask();
        m.pc = '1;
    endfunction

    // ---------------- helpers ----------------
    function automatic out_t sample_dut();
        out_t a;
        a.valid = bus.valid_o; a.pc = bus.pc_o;
        a.rs1 = bus.rs1_addr_o; a.rs2 = bus.rs2_addr_o; a.rd = bus.rd_addr_o;
        a.rd_we = bus.rd_we_o; a.imm = bus.imm_o; a.alu_op = bus.alu_op_o;
        a.src_a = bus.alu_src_a_o; a.src_b = bus.alu_src_b_o;
        a.mem_req = bus.mem_req_o; a.mem_we = bus.mem_we_o;
        a.mem_size = bus.mem_size_o; a.mem_unsigned = bus.mem_unsigned_o;
        a.branch = bus.branch_o; a.jal = bus.jal_o; a.jalr = bus.jalr_o;
        a.branch_cond = bus.branch_cond_o; a.ecall = bus.ecall_o;
        a.ebreak = bus.ebreak_o; a.fence = bus.fence_o; a.illegal = bus.illegal_o;
        return a;
    endfunction

    task automatic check_bundle(input string name, input out_t exp, input out_t care);
        logic [$bits(out_t)-1:0] av = sample_dut();
        logic [$bits(out_t)-1:0] ev = exp;
        logic [$bits(out_t)-1:0] cv = care;
        checks++;
        if (((av ^ ev) & cv) != '0) begin
            failures++;
            $display("FAIL %s actual=%h required=%h care=%h", name, av, ev, cv);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic [31:0] pc,
                         input logic st, input logic fl);
        bus.instruction_i = ins; bus.instruction_valid_i = v; bus.pc_i = pc;
        bus.stall_i = st; bus.flush_i = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom();
        if ($urandom_range(0, 9) != 0) ins[6:0] = OPS[$urandom_range(0, 10)];
        case ($urandom_range(0, 5))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 15) == 0) ins = $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
        return ins;
    endfunction

    // ---------------- test ----------------
    initial begin
        vec_t vecs[14];
        out_t e, m, full_m, bub_m, zero;
        full_m = '1;
        bub_m  = ctl_mask();
        zero   = '0;

        vecs[0]  = '{32'h00500093, 0,1,0,0, 5'd1,5'd0,5'd0, 32'h5,        ALU_ADD,1,2'd0, 1,0,1,1};
        vecs[1]  = '{32'hFFF00093, 0,1,0,0, 5'd1,5'd0,5'd0, 32'hFFFFFFFF, ALU_ADD,1,2'd0, 1,0,1,1};
        vecs[2]  = '{32'h123452B7, 0,1,0,0, 5'd5,5'd0,5'd0, 32'h12345000, ALU_ADD,1,2'd0, 1,0,1,1};
        vecs[3]  = '{32'h0020A423, 0,0,1,1, 5'd0,5'd1,5'd2, 32'h8,        ALU_ADD,1,2'd2, 1,1,1,1};
`ifdef AURIGA_RV32M_EN
        vecs[4]  = '{32'h022081B3, 0,1,0,0, 5'd3,5'd1,5'd2, 32'h0,        ALU_MUL,0,2'd0, 1,1,0,1};
`else
        vecs[4]  = '{32'h022081B3, 1,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,0,2'd0, 0,0,0,0};
`endif
        vecs[5]  = '{32'h00000000, 1,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,0,2'd0, 0,0,0,0};
        vecs[6]  = '{32'h00000013, 0,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,1,2'd0, 1,0,1,1};
        vecs[7]  = '{32'hFFC12183, 0,1,1,0, 5'd3,5'd2,5'd0, 32'hFFFFFFFC, ALU_ADD,1,2'd2, 1,0,1,1};
        vecs[8]  = '{32'h40309093, 1,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,0,2'd0, 0,0,0,0};
        vecs[9]  = '{32'h4030D093, 0,1,0,0, 5'd1,5'd1,5'd0, 32'h0,        ALU_SRA,1,2'd0, 1,0,0,1};
        vecs[10] = '{32'h00500091, 1,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,0,2'd0, 0,0,0,0};
        vecs[11] = '{32'h00002063, 1,0,0,0, 5'd0,5'd0,5'd0, 32'h0,        ALU_ADD,0,2'd0, 0,0,0,0};
        vecs[12] = '{32'h402081B3, 0,1,0,0, 5'd3,5'd1,5'd2, 32'h0,        ALU_SUB,0,2'd0, 1,1,0,1};
        vecs[13] = '{32'h00104203, 0,1,1,0, 5'd4,5'd0,5'd0, 32'h1,        ALU_ADD,1,2'd0, 1,0,1,1};

        // reset state
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        check_bundle("reset_state", zero, full_m);
        rst_n = 1'b1;

        // table vectors, one per cycle
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ins, 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(bus.valid_o), 32'd1);
            chk($sformatf("v%0d_pc", i), bus.pc_o, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_o), 32'(vecs[i].illegal));
            chk($sformatf("v%0d_rd_we", i), 32'(bus.rd_we_o), 32'(vecs[i].rd_we));
            chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req_o), 32'(vecs[i].mem_req));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we_o), 32'(vecs[i].mem_we));
            if (vecs[i].illegal)
                chk($sformatf("v%0d_ctl", i),
                    32'({bus.branch_o, bus.jal_o, bus.jalr_o, bus.ecall_o, bus.ebreak_o, bus.fence_o}), 32'd0);
            if (vecs[i].rd_we) chk($sformatf("v%0d_rd", i), 32'(bus.rd_addr_o), 32'(vecs[i].rd));
            if (vecs[i].mem_req) chk($sformatf("v%0d_size", i), 32'(bus.mem_size_o), 32'(vecs[i].size));
            if (vecs[i].c_rs1) chk($sformatf("v%0d_rs1", i), 32'(bus.rs1_addr_o), 32'(vecs[i].rs1));
            if (vecs[i].c_rs2) chk($sformatf("v%0d_rs2", i), 32'(bus.rs2_addr_o), 32'(vecs[i].rs2));
            if (vecs[i].c_imm) chk($sformatf("v%0d_imm", i), bus.imm_o, vecs[i].imm);
            if (vecs[i].c_alu) begin
                chk($sformatf("v%0d_alu", i), 32'(bus.alu_op_o), 32'(vecs[i].alu));
                chk($sformatf("v%0d_src_b", i), 32'(bus.alu_src_b_o), 32'(vecs[i].src_b));
            end
        end

        // bubble
        drive(32'h00500093, 1'b0, 32'h2000, 1'b0, 1'b0);
        tick();
        check_bundle("bubble", zero, bub_m);

        // stall holds for 3 cycles while new input is presented
        drive(32'h00500093, 1'b1, 32'h3000, 1'b0, 1'b0);
        tick();
        ref_decode(32'h00500093, 32'h3000, e, m);
        check_bundle("stall_load", e, m);
        drive(32'h123452B7, 1'b1, 32'h3004, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bundle($sformatf("stall_hold%0d", c), e, full_m & m);
        end
        // flush wins over stall
        drive(32'h123452B7, 1'b1, 32'h3004, 1'b1, 1'b1);
        tick();
        check_bundle("flush_over_stall", zero, bub_m);

        // async reset mid-stall
        drive(32'h00500093, 1'b1, 32'h4000, 1'b0, 1'b0);
        tick();
        drive(32'h123452B7, 1'b1, 32'h4004, 1'b1, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1 check_bundle("async_reset", zero, full_m);
        tick();
        check_bundle("reset_held", zero, full_m);
        drive(32'h123452B7, 1'b1, 32'h4004, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        ref_decode(32'h123452B7, 32'h4004, e, m);
        check_bundle("first_after_reset", e, m);

        // randomized traffic against the reference model
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        e = '0; m = bub_m;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins = rand_instr();
            logic [31:0] pcv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            logic v  = ($urandom_range(0, 3) != 0);
            logic st = ($urandom_range(0, 5) == 0);
            logic fl = ($urandom_range(0, 11) == 0);
            drive(ins, v, pcv, st, fl);
            tick();
            if (fl) begin
                e = '0; m = bub_m;
            end else if (!st) begin
                if (v) ref_decode(ins, pcv, e, m);
                else begin e = '0; m = bub_m; end
            end
            check_bundle("random", e, m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
